// File: rtl/i2s_tdm_tx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg: shared types for the serial audio transmitter.
//   i2s_mode_e    : serial format selector (Philips I2S, left-justified, TDM)
//   tx_state_e    : transmitter control state (IDLE, RUN)
//   sanitize_mode : folds the reserved encoding onto Philips I2S
// ---------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [1:0] {
    I2S_PHILIPS = 2'b00,
    I2S_LJ      = 2'b01,
    I2S_TDM     = 2'b10
  } i2s_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

  // Reserved encoding 2'b11 behaves as Philips I2S.
  function automatic i2s_mode_e sanitize_mode(input logic [1:0] m);
    case (m)
      2'b01:   return I2S_LJ;
      2'b10:   return I2S_TDM;
      default: return I2S_PHILIPS;
    endcase
  endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx_if: frame handshake between the mixer output stage and the
// transmitter.
//   frame_data  : one whole frame, channel 0 in the LSBs
//   frame_valid : producer has a frame on frame_data
//   frame_ready : transmitter FIFO can accept a frame
// Modports: master (producer), slave (transmitter).
// ---------------------------------------------------------------------------
interface i2s_tdm_tx_if #(
  parameter int DATA_W = 48
);
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;

  modport master (output frame_data, output frame_valid, input  frame_ready);
  modport slave  (input  frame_data, input  frame_valid, output frame_ready);
endinterface

// File: rtl/i2s_tdm_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo: single-clock FIFO with registered occupancy.
//   i_clk, i_rst_n : clock, synchronous active-low reset (pointers/level only)
//   i_push, i_data : write request and data (ignored while full)
//   i_pop          : read request (ignored while empty)
//   o_data         : head entry (valid while not empty)
//   o_full/o_empty : decoded from the registered level
//   o_level        : number of entries stored
// A push into an empty FIFO becomes visible to the read side one cycle later.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign o_full  = (level_q == (AW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; resetting the pointers discards the contents.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_push) mem_q[wr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_q];
  assign o_level = level_q;

endmodule

// File: rtl/i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx: multi-channel serial audio transmitter (Philips I2S,
// left-justified, TDM/DSP-A) with BCLK/LRCLK generated from i_clk.
//   i_clk, i_rst_n  : system clock, synchronous active-low reset
//   i_enable        : run request; a disable completes the current frame
//   i_mode          : serial format, latched at every frame start
//   frame_if        : frame handshake (slave side), frames buffered in a FIFO
//   o_fifo_level    : frames stored in the FIFO
//   o_underrun      : one-cycle pulse when a frame starts with the FIFO empty
//   o_bclk, o_lrclk, o_sda : serial pins (o_lrclk is WS or FS)
// ---------------------------------------------------------------------------
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  i2s_mode_e                     i_mode,
  i2s_tdm_tx_if.slave                   frame_if,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_underrun,
  output logic                          o_bclk,
  output logic                          o_lrclk,
  output logic                          o_sda
);
  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam int N       = CHANNELS * SLOT_W;
  localparam int POS_W   = $clog2(N);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N - 1);
  localparam logic [POS_W-1:0] POS_HALF = POS_W'(N / 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  // WS/FS level for frame position p.
  function automatic logic ws_level(input i2s_mode_e m, input logic [POS_W-1:0] p);
    case (m)
      I2S_LJ:  return (p < POS_HALF);
      I2S_TDM: return (p == '0);
      default: return (p >= POS_HALF);
    endcase
  endfunction

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [N-1:0]     sr_q, sr_d;
  i2s_mode_e        mode_q, mode_d;
  logic             lrclk_q, lrclk_d;
  logic             sda_q, sda_d;
  logic             underrun_q, underrun_d;

  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [N-1:0]       stream;
  logic               tick, fall, wrap, start, drive, prev_bit;

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (frame_if.frame_valid),
    .i_data  (frame_if.frame_data),
    .i_pop   (start),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  assign frame_if.frame_ready = ~fifo_full;

  // Serial image of the head frame: slot s holds channel s, sample MSB at the
  // top of the slot and zero padding below. An empty FIFO yields silence.
  always_comb begin
    stream = '0;
    if (!fifo_empty) begin
      for (int s = 0; s < CHANNELS; s++) begin
        stream[(CHANNELS-1-s)*SLOT_W + (SLOT_W-SAMPLE_W) +: SAMPLE_W] =
          fifo_rdata[s*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // tick: divider terminal count; fall: BCLK 1->0, the frame-position step.
  always_comb begin
    tick  = (state_q == RUN) && (div_q == DIV_LAST);
    fall  = tick && bclk_q;
    wrap  = fall && (pos_q == POS_LAST);
    start = ((state_q == IDLE) && i_enable) || (wrap && i_enable);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (wrap && !i_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    pos_d      = pos_q;
    sr_d       = sr_q;
    mode_d     = mode_q;
    lrclk_d    = lrclk_q;
    sda_d      = sda_q;
    underrun_d = 1'b0;
    drive      = 1'b0;
    // The bit leaving the top of the shift register is the one-BCLK-delayed
    // data for I2S/TDM; after IDLE there is no previous frame, so it is 0.
    prev_bit   = (state_q == RUN) ? sr_q[N-1] : 1'b0;

    if (state_q == RUN) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) bclk_d = ~bclk_q;
      if (fall) begin
        pos_d = pos_q + POS_W'(1);
        sr_d  = sr_q << 1;
        drive = 1'b1;
      end
    end

    if (start) begin
      div_d      = '0;
      bclk_d     = 1'b0;
      pos_d      = '0;
      sr_d       = stream;
      mode_d     = sanitize_mode(i_mode);
      underrun_d = fifo_empty;
      drive      = 1'b1;
    end

    if (drive) begin
      lrclk_d = ws_level(mode_d, pos_d);
      sda_d   = (mode_d == I2S_LJ) ? sr_d[N-1] : prev_bit;
    end

    if (state_d == IDLE) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      pos_d   = '0;
      lrclk_d = 1'b0;
      sda_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bclk_q     <= 1'b0;
      pos_q      <= '0;
      lrclk_q    <= 1'b0;
      sda_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      pos_q      <= pos_d;
      lrclk_q    <= lrclk_d;
      sda_q      <= sda_d;
      underrun_q <= underrun_d;
    end
  end

  // Frame data and mode are always reloaded at frame start before use.
  always_ff @(posedge i_clk) begin
    sr_q   <= sr_d;
    mode_q <= mode_d;
  end

  assign o_bclk     = bclk_q;
  assign o_lrclk    = lrclk_q;
  assign o_sda      = sda_q;
  assign o_underrun = underrun_q;

endmodule
